// File: rtl/timer_ctrl_pkg.sv
// Shared types and default timing for the timer push-button front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_ctrl_pkg;

  // Counter sequencing state as seen on the STATE output.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } timer_state_t;

  // Defaults assume a 100 MHz core clock: 10 ms debounce, 1 s long press.
  localparam int DEF_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int DEF_LONG_PRESS_CYCLES = 100_000_000;

endpackage

// File: rtl/timer_input_ctrl_if.sv
// Pin-side buttons in, counter controls out, for the timer input controller.
// Latency: n/a (wires only).
// Backpressure: none; buttons are free-running levels, outputs are levels/pulses.
// Ports: BTN_SS/BTN_CLR raw buttons, RUN enable, CLEAR strobe, STATE encoding.
interface timer_input_ctrl_if;
  import timer_ctrl_pkg::*;

  logic         BTN_SS;
  logic         BTN_CLR;
  logic         RUN;
  logic         CLEAR;
  timer_state_t STATE;

  // master drives the buttons (board/bench), slave is the controller
  modport master (output BTN_SS, output BTN_CLR, input RUN, input CLEAR, input STATE);
  modport slave  (input BTN_SS, input BTN_CLR, output RUN, output CLEAR, output STATE);
endinterface

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one push-button, emitting stable level and edge pulses.
// Latency: stable moves 3+DEBOUNCE_CYCLES edges after the raw edge; rise/fall move with it.
// Backpressure: none; rise/fall are single-cycle pulses.
// Ports: clk, rst_n, btn_raw async input, stable level, rise/fall one-cycle pulses.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          btn_sync;
  logic          stable_q, stable_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  synchronizer #(.STAGES(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  // The level must disagree with stable on DEBOUNCE_CYCLES consecutive
  // samples; any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (btn_sync == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_d = btn_sync;
      db_cnt_d = '0;
      rise_d   = btn_sync;
      fall_d   = ~btn_sync;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: STAGES clock edges from the first sampling edge.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), d async input, q synchronized output.
module synchronizer #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/timer_input_ctrl.sv
// Button front end: debounce, short/long press detection, run/pause/clear FSM.
// Latency: outputs move 3+DEBOUNCE_CYCLES+2 edges after a raw button edge.
// Backpressure: none; CLEAR is a one-cycle strobe, RUN/STATE are levels.
// Ports: CLK, RST_N (async active-low), io slave modport (buttons in, RUN/CLEAR/STATE out).
module timer_input_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic               CLK,
  input  logic               RST_N,
  timer_input_ctrl_if.slave  io
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_RUNNING = RUNNING;
  localparam logic [1:0] ST_PAUSED  = PAUSED;

  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_PRESS_CYCLES - 1);

  logic ss_stable, ss_rise, ss_fall;
  logic clr_stable, clr_rise, clr_fall;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk (CLK), .rst_n (RST_N), .btn_raw (io.BTN_SS),
    .stable (ss_stable), .rise (ss_rise), .fall (ss_fall)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk (CLK), .rst_n (RST_N), .btn_raw (io.BTN_CLR),
    .stable (clr_stable), .rise (clr_rise), .fall (clr_fall)
  );

  // Debouncer outputs this controller has no use for.
  logic unused_evt;
  assign unused_evt = ^{ss_rise, clr_stable, clr_fall};

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          ss_long_q, ss_long_d;
  logic          ss_short_q, ss_short_d;
  logic          clr_press_q, clr_press_d;
  logic [1:0]    state_q, state_d;
  logic          run_q, run_d;
  logic          clear_q, clear_d;

  // Hold counter saturates so ss_long fires exactly once per hold.
  // On the release pulse the counter still holds the full hold length,
  // so reaching HOLD_MAX means ss_long already fired for this press.
  always_comb begin
    hold_cnt_d  = '0;
    if (ss_stable) begin
      hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + 1'b1;
    end
    ss_long_d   = ss_stable && (hold_cnt_q == HOLD_PRE);
    ss_short_d  = ss_fall && (hold_cnt_q != HOLD_MAX);
    clr_press_d = clr_rise;
  end

  // Priority: ss_long > clr_press > ss_short; losers are dropped.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    if (ss_long_q) begin
      state_d = ST_IDLE;
      clear_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_press_q) begin
            clear_d = 1'b1;
          end else if (ss_short_q) begin
            state_d = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          // clearing a running counter is refused
          if (ss_short_q) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (clr_press_q) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
          end else if (ss_short_q) begin
            state_d = ST_RUNNING;
          end
        end
        default: begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      endcase
    end
    run_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_cnt_q  <= '0;
      ss_long_q   <= 1'b0;
      ss_short_q  <= 1'b0;
      clr_press_q <= 1'b0;
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      ss_long_q   <= ss_long_d;
      ss_short_q  <= ss_short_d;
      clr_press_q <= clr_press_d;
      state_q     <= state_d;
      run_q       <= run_d;
      clear_q     <= clear_d;
    end
  end

  assign io.RUN   = run_q;
  assign io.CLEAR = clear_q;
  assign io.STATE = timer_state_t'(state_q);

endmodule

// File: tb/tb_timer_input_ctrl.sv
// Self-checking bench for timer_input_ctrl with a cycle-stamped output scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_input_ctrl;
  import timer_ctrl_pkg::*;

  localparam int DB = 4;
  localparam int LP = 20;

  logic CLK = 1'b0;
  logic RST_N;

  timer_input_ctrl_if io();

  timer_input_ctrl #(
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .io    (io)
  );

  always #5 CLK = ~CLK;

  int unsigned edge_cnt = 0;
  always @(posedge CLK) edge_cnt++;

  typedef struct {
    int unsigned edge_no;
    logic [1:0]  st;
    logic        run;
    logic        clr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  exp_state = 2'd0;
  logic [3:0]  exp_cur   = 4'd0;
  logic [3:0]  prev_out  = 4'd0;
  logic [3:0]  mon_cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every output change must match the next scoreboard entry, including its edge.
  always @(negedge CLK) begin
    mon_cur = {io.STATE, io.RUN, io.CLEAR};
    if (!RST_N) begin
      prev_out = mon_cur;
    end else if (mon_cur !== prev_out) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", {28'd0, mon_cur}, {28'd0, exp_cur});
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_edge",  edge_cnt, mon_e.edge_no);
        chk("out_state", io.STATE, mon_e.st);
        chk("out_run",   io.RUN,   mon_e.run);
        chk("out_clear", io.CLEAR, mon_e.clr);
        exp_cur = {mon_e.st, mon_e.run, mon_e.clr};
      end
      prev_out = mon_cur;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Reference FSM: push the output changes an event set produces at edge 'at'.
  task automatic predict(input int unsigned at, input bit lng, input bit clr, input bit sht);
    logic [1:0] ns;
    bit         pulse;
    ns    = exp_state;
    pulse = 1'b0;
    if (lng) begin
      ns = IDLE; pulse = 1'b1;
    end else if (clr && exp_state != RUNNING) begin
      ns = IDLE; pulse = 1'b1;
    end else if (sht) begin
      ns = (exp_state == RUNNING) ? PAUSED : RUNNING;
    end
    if (pulse) begin
      sb_q.push_back('{at,     ns, ns == RUNNING, 1'b1});
      sb_q.push_back('{at + 1, ns, ns == RUNNING, 1'b0});
    end else if (ns != exp_state) begin
      sb_q.push_back('{at, ns, ns == RUNNING, 1'b0});
    end
    exp_state = ns;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      step(1);
      k++;
    end
    chk({tag, "_drain"}, sb_q.size(), 0);
    step(12);
    chk({tag, "_state"}, io.STATE, exp_state);
    chk({tag, "_run"},   io.RUN,   exp_state == RUNNING);
    chk({tag, "_clear"}, io.CLEAR, 0);
  endtask

  // Hold BTN_SS for n cycles; optionally raise BTN_CLR on the release edge.
  task automatic press_ss(input int n, input bit with_clr, input string tag);
    int unsigned e;
    step(1);
    e = edge_cnt;
    io.BTN_SS = 1'b1;
    if (n >= LP)      predict(e + DB + 3 + LP + 1, 1'b1, 1'b0, 1'b0);
    else if (n >= DB) predict(e + n + DB + 5, 1'b0, with_clr, 1'b1);
    step(n);
    io.BTN_SS = 1'b0;
    if (with_clr) io.BTN_CLR = 1'b1;
    drain(tag);
    if (with_clr) begin
      io.BTN_CLR = 1'b0;
      step(15);
    end
  endtask

  task automatic press_clr(input int n, input string tag);
    int unsigned e;
    step(1);
    e = edge_cnt;
    io.BTN_CLR = 1'b1;
    predict(e + DB + 5, 1'b0, 1'b1, 1'b0);
    step(n);
    io.BTN_CLR = 1'b0;
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time budget exceeded, %0d entries pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    io.BTN_SS  = 1'b0;
    io.BTN_CLR = 1'b0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    chk("reset_run",   io.RUN,   0);
    chk("reset_clear", io.CLEAR, 0);
    chk("reset_state", io.STATE, IDLE);
    step(3);
    RST_N = 1'b1;
    step(3);

    press_ss(3, 1'b0, "glitch3");
    press_ss(10, 1'b0, "start");
    press_ss(5, 1'b0, "pause5");
    press_ss(6, 1'b0, "resume");
    press_clr(6, "clr_running");
    press_ss(6, 1'b0, "pause");
    press_clr(6, "clr_paused");
    press_clr(6, "clr_idle");
    press_ss(8, 1'b0, "start2");
    press_ss(40, 1'b0, "long");
    press_ss(6, 1'b0, "start3");
    press_ss(6, 1'b0, "pause3");
    press_ss(6, 1'b1, "coincide");
    press_ss(6, 1'b0, "start4");

    // Reset mid-hold while RUNNING: outputs must drop with no clock edge.
    step(1);
    io.BTN_SS = 1'b1;
    step(10);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_run",   io.RUN,   0);
    chk("midrst_clear", io.CLEAR, 0);
    chk("midrst_state", io.STATE, IDLE);
    exp_state = IDLE;
    exp_cur   = 4'd0;
    step(5);
    io.BTN_SS = 1'b0;
    step(3);
    RST_N = 1'b1;
    step(60);
    chk("postrst_pending", sb_q.size(), 0);
    chk("postrst_state",   io.STATE, IDLE);
    chk("postrst_clear",   io.CLEAR, 0);
    press_ss(6, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_input_ctrl.md
# timer_input_ctrl

Front-end controller for the timer's push-buttons. It passes two raw button inputs through the three-stage `synchronizer`, debounces them, and classifies presses as short or long. A run/pause/clear state machine then drives the timer counter's `RUN` enable and one-cycle `CLEAR` strobe. It sits between the board pins and the timer core. It is the only block allowed to sequence the counter.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronized level must differ from the stable level before it is accepted (10 ms at 100 MHz); minimum 2.
- `LONG_PRESS_CYCLES`, default 100_000_000: stable-high hold time that makes a start/stop press "long" (1 s); must exceed `DEBOUNCE_CYCLES`.
- `CLK` input 1: system clock. One clock domain only.
- `RST_N` input 1: reset, asynchronous, active-low.
- `BTN_SS` input 1: raw start/stop button, asynchronous, active-high.
- `BTN_CLR` input 1: raw clear button, asynchronous, active-high.
- `RUN` output 1: counter enable, registered level.
- `CLEAR` output 1: counter clear, registered one-cycle pulse.
- `STATE` output 2: current FSM state, encoded as `timer_state_t`.

## Operation
- Each button goes through `synchronizer` and then a debouncer.
- Debouncer behaviour:
  - Holds `stable` (reset 0) and a counter `db_cnt` (reset 0).
  - If the synchronized level equals `stable`, clear `db_cnt`.
  - Otherwise increment `db_cnt`. When it reaches `DEBOUNCE_CYCLES-1` and the level still differs, `stable` takes the new level and `db_cnt` clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
- Event generation, each event a single registered pulse:
  - `clr_press`: `BTN_CLR` `stable` rises 0→1.
  - `ss_long`: `BTN_SS` `stable` has been high for `LONG_PRESS_CYCLES` cycles, counted by `hold_cnt`, which saturates and clears on release. Fires once per hold.
  - `ss_short`: `BTN_SS` `stable` falls 1→0 and `ss_long` did not fire during that hold.
- FSM states: IDLE=0, RUNNING=1, PAUSED=2. Reset state is IDLE. Encoding 3 is illegal and recovers to IDLE with `CLEAR`.
- IDLE transitions:
  - `ss_short` → RUNNING.
  - `clr_press` → stay in IDLE, pulse `CLEAR`.
- RUNNING transitions:
  - `ss_short` → PAUSED.
  - `clr_press` is ignored.
- PAUSED transitions:
  - `ss_short` → RUNNING.
  - `clr_press` → IDLE, pulse `CLEAR`.
- `ss_long` in any state → IDLE, pulse `CLEAR`. This is the forced reset.
- Priority when events coincide in one cycle: `ss_long` > `clr_press` > `ss_short`. The lower-priority event is dropped, not queued.
- `RUN` = 1 exactly while STATE = RUNNING.

## Timing
- Reset values: `RUN`=0, `CLEAR`=0, `STATE`=IDLE. All synchronizer stages, `stable`, `db_cnt`, `hold_cnt` and event registers are 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Presses held across reset release are treated as new presses after debounce. No event may fire on the reset-release edge.
- Latency from a raw edge sampled at clock edge 0:
  - Synchronized level changes at edge 3.
  - `stable` changes at edge 3+`DEBOUNCE_CYCLES`.
  - The event pulse is high in the following cycle.
  - `RUN`, `STATE` and `CLEAR` update at edge 3+`DEBOUNCE_CYCLES`+2.
- `ss_long` is asserted `LONG_PRESS_CYCLES` cycles after `stable` rises, then the outputs update one edge later.
- `CLEAR` is high for exactly one cycle per qualifying event. Back-to-back events give separated pulses, because each needs a debounced edge.
- Width rules:
  - `db_cnt` is `$clog2(DEBOUNCE_CYCLES)` bits.
  - `hold_cnt` is `$clog2(LONG_PRESS_CYCLES+1)` bits and saturates at `LONG_PRESS_CYCLES` with no wrap.

## Structure
- `timer_ctrl_pkg`: `timer_state_t` enum (IDLE, RUNNING, PAUSED, 2-bit) and the default timing constants.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`):
  - Instantiates `synchronizer` and outputs `stable` plus rise/fall pulses.
  - Instantiated twice.
- Long-press counter and FSM live in `timer_input_ctrl`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=20.
- Reset/start: deassert `RST_N` and hold both buttons 0 → `RUN`=0, `CLEAR`=0, `STATE`=0. Then press `BTN_SS` for 10 cycles and release → `STATE`=1 and `RUN`=1 at edge 9 after the release edge.
- Glitch: toggle `BTN_SS` high for 3 cycles → no state change, `RUN` stays 0. Toggle it for 5 cycles → short press recognized.
- Pause/clear: RUNNING, short `BTN_SS` → `STATE`=2. `BTN_CLR` in RUNNING → ignored. `BTN_CLR` in PAUSED → `STATE`=0 and one-cycle `CLEAR`=1.
- Long press: RUNNING, hold `BTN_SS` 40 cycles → `STATE`=0 and `CLEAR` pulse after 20 stable cycles + 1 edge. Release → no extra event and `STATE` stays 0.
- Coincidence: PAUSED, `ss_short` and `clr_press` in the same cycle → `STATE`=0 and `CLEAR`=1; the short press is dropped.
- Reset mid-hold: assert `RST_N`=0 during a 15-cycle `BTN_SS` hold → outputs go to reset values with no clock edge. After release there is no spurious `CLEAR`.
